multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port opcode  input  4  opcode field from the external IR (valid from DECODE onward).
REQ-004 SHALL have port zero  input  1  ALU Zero flag; 1 means branch condition true for codes 3 and 6.
REQ-005 SHALL have port mem_ready  input  1  memory completion strobe.
REQ-006 SHALL have outputs mem_req, mem_read, mem_write, iord  each output 1: memory request, direction, address select (0 = PC, 1 = ALU result).
REQ-007 SHALL have outputs ir_write, pc_write, pc_src, reg_write, mem_to_reg  each output 1 (pc_src: 0 = PC+1, 1 = branch target).
REQ-008 SHALL have port alu_ctl  output  4  ALU operation code.
REQ-009 SHALL have ports halted  output  1 and illegal  output  1.
REQ-010 SHALL have port retired  output  16  retired-instruction count, present only under CTRL_PERF_EN.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, EXEC, WB, MEMADDR, MEMACC, MEMWB, BRANCH, HALT; outputs decoded from state, plus opcode and zero where stated.
REQ-012 Opcode map SHALL be 0 NOP, 1 HLF, 2 LFH, 3 BNE, 4 LW, 5 SW, 6 BEQ, 7 CNT, 8 SET, 15 HALT; codes 9-14 are illegal.
REQ-013 FETCH SHALL assert mem_req=1, mem_read=1, iord=0, and hold FETCH until mem_ready=1; in that cycle it SHALL assert ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
REQ-014 DECODE SHALL last one cycle and route: 1/2/7/8 -> EXEC; 4/5 -> MEMADDR; 3/6 -> BRANCH; 15 -> HALT; 0 -> FETCH; illegal -> FETCH with illegal=1 for that cycle.
REQ-015 EXEC SHALL drive alu_ctl=opcode for one cycle, then go to WB; WB SHALL assert reg_write=1, mem_to_reg=0, then go to FETCH.
REQ-016 MEMADDR SHALL drive alu_ctl=opcode (4 or 5) for one cycle, then go to MEMACC.
REQ-017 MEMACC SHALL assert mem_req=1, iord=1, mem_read=1 for LW or mem_write=1 for SW, and wait for mem_ready.
REQ-018 On mem_ready in MEMACC, LW SHALL go to MEMWB and SW SHALL go to FETCH.
REQ-019 MEMWB SHALL assert reg_write=1, mem_to_reg=1, then go to FETCH.
REQ-020 BRANCH SHALL drive alu_ctl=opcode with pc_src=1 and pc_write=zero, then go to FETCH.
REQ-021 HALT SHALL assert halted=1, keep all other outputs 0, and remain until reset.
REQ-022 mem_req and its qualifiers SHALL stay stable until the mem_ready cycle; mem_ready while mem_req=0 SHALL be ignored.
REQ-023 Zero-wait latency SHALL be NOP 2, BRANCH 3, SW 4, ALU op 4, LW 5 cycles; each mem_ready-low cycle adds one.
REQ-024 In every state, outputs not explicitly asserted SHALL be 0, and alu_ctl SHALL be 0.

Reset
REQ-025 While reset=1, all outputs SHALL be 0 and the next state SHALL be FETCH, including reset during MEMACC or HALT.
REQ-026 mem_req SHALL be 0 in any cycle where reset was sampled high on the preceding edge.

Configuration
REQ-027 With CTRL_PERF_EN defined, retired SHALL reset to 0 and increment by 1 on every transition into FETCH from WB, MEMWB, BRANCH, DECODE (NOP or illegal) or MEMACC (SW), wrapping 0xFFFF -> 0.
REQ-028 Without CTRL_PERF_EN, the retired port and counter SHALL be absent.

Structure
REQ-029 Package ctrl_pkg SHALL hold the opcode constants and the state encoding typedef.
REQ-030 The combinational opcode classifier SHALL be sub-module ctrl_decoder (opcode -> class, illegal).

Verification
REQ-031 Reset, then opcode=7 with mem_ready always 1: ir_write at cycle 1, alu_ctl=7 at cycle 3, reg_write at cycle 4, back to FETCH.
REQ-032 LW with mem_ready low for 2 MEMACC cycles: mem_req/iord/mem_read held 3 cycles; MEMWB asserts mem_to_reg=1, reg_write=1.
REQ-033 BEQ (opcode 6): zero=1 gives pc_write=1, pc_src=1; zero=0 gives pc_write=0; BNE (3) behaves identically.
REQ-034 opcode=11: illegal=1 for one DECODE cycle, no reg_write or memory access, next state FETCH.
REQ-035 opcode=15: halted stays 1 for 20 cycles; reset during MEMACC drops mem_req next cycle, then FETCH resumes.
REQ-036 CTRL_PERF_EN: after NOP, SW, BEQ, CNT, retired=4.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcode map, FSM state
// encoding and opcode classes produced by the decoder.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_HLF  = 4'd1;
  localparam logic [3:0] OP_LFH  = 4'd2;
  localparam logic [3:0] OP_BNE  = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_CNT  = 4'd7;
  localparam logic [3:0] OP_SET  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_MEMADDR,
    S_MEMACC,
    S_MEMWB,
    S_BRANCH,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_MEM,
    C_BR,
    C_HALT,
    C_ILL
  } cls_e;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode classifier: maps the 4-bit opcode to the routing
// class used in DECODE and flags the unassigned codes 9..14.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output cls_e       cls,
  output logic       illegal
);

  // classify opcode; anything outside the map is illegal
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_NOP:                          cls = C_NOP;
      OP_HLF, OP_LFH, OP_CNT, OP_SET:  cls = C_ALU;
      OP_LW, OP_SW:                    cls = C_MEM;
      OP_BNE, OP_BEQ:                  cls = C_BR;
      OP_HALT:                         cls = C_HALT;
      default:                         cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM. Sequences fetch/decode/execute/memory/branch
// phases and drives datapath strobes from the current state.
// Optional build macro CTRL_PERF_EN adds the 16-bit retired-instruction
// counter output.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [3:0]  alu_ctl,
  output logic        halted,
  output logic        illegal
`ifdef CTRL_PERF_EN
  ,
  output logic [15:0] retired
`endif
);

  state_e state, nxt;
  cls_e   cls;
  logic   dec_ill;
  logic   rst_q;

  ctrl_decoder u_dec (
    .opcode  (opcode),
    .cls     (cls),
    .illegal (dec_ill)
  );

  // state register; rst_q blanks the first FETCH cycle after reset
  always_ff @(posedge clock) begin
    rst_q <= reset;
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  // next-state and Moore outputs; reset forces every output low
  always_comb begin
    nxt        = state;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_ctl    = 4'd0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        // no request in the cycle right after reset, so mem_ready is ignored
        if (!rst_q) begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        illegal = dec_ill;
        case (cls)
          C_ALU:   nxt = S_EXEC;
          C_MEM:   nxt = S_MEMADDR;
          C_BR:    nxt = S_BRANCH;
          C_HALT:  nxt = S_HALT;
          default: nxt = S_FETCH;
        endcase
      end
      S_EXEC: begin
        alu_ctl = opcode;
        nxt     = S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMADDR: begin
        alu_ctl = opcode;
        nxt     = S_MEMACC;
      end
      S_MEMACC: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode != OP_LW);
        if (mem_ready) nxt = (opcode == OP_LW) ? S_MEMWB : S_FETCH;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_ctl  = opcode;
        pc_src   = 1'b1;
        pc_write = zero;
        nxt      = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_ctl    = 4'd0;
      halted     = 1'b0;
      illegal    = 1'b0;
    end
  end

`ifdef CTRL_PERF_EN
  logic [15:0] ret_cnt;

  // count every instruction completion (any return to FETCH from a work state)
  always_ff @(posedge clock) begin
    if (reset)                                  ret_cnt <= 16'd0;
    else if (state != S_FETCH && nxt == S_FETCH) ret_cnt <= ret_cnt + 16'd1;
  end

  assign retired = reset ? 16'd0 : ret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// directed instruction into its expected per-cycle outputs; a single
// process drives each cycle and compares, then literal pins check timing.
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_read, mem_write, iord;
  logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg;
  logic [3:0]  alu_ctl;
  logic        halted, illegal;
`ifdef CTRL_PERF_EN
  logic [15:0] retired;
`endif

  always #5 clock = ~clock;

  multicycle_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_ctl    (alu_ctl),
    .halted     (halted),
    .illegal    (illegal)
`ifdef CTRL_PERF_EN
    ,
    .retired    (retired)
`endif
  );

  typedef struct packed {
    logic        mem_req, mem_read, mem_write, iord;
    logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg;
    logic [3:0]  alu_ctl;
    logic        halted, illegal;
    logic [15:0] retired;
  } outv_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] op;
    logic       z;
    logic       rdy;
    outv_t      exp;
  } stim_t;

  stim_t       q[$];
  outv_t       lg[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] ret_m   = 16'd0;

  task automatic push(input logic rst, input logic [3:0] op, input logic z,
                      input logic rdy, input outv_t e);
    stim_t s;
    s.rst = rst; s.op = op; s.z = z; s.rdy = rdy; s.exp = e;
    s.exp.retired = rst ? 16'd0 : ret_m;
    q.push_back(s);
  endtask

  // n reset cycles, then the blank cycle with no memory request
  task automatic push_reset(input int n);
    outv_t e;
    e = '0;
    ret_m = 16'd0;
    for (int i = 0; i < n; i++) push(1'b1, 4'd0, 1'b0, 1'b1, e);
    push(1'b0, 4'd0, 1'b0, 1'b1, e);
  endtask

  // expand one instruction: fw fetch wait cycles, mw memory wait cycles
  task automatic gen(input logic [3:0] op, input logic z, input int fw, input int mw);
    outv_t e;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1; e.mem_read = 1;
      push(1'b0, op, z, 1'b0, e);
    end
    e = '0; e.mem_req = 1; e.mem_read = 1; e.ir_write = 1; e.pc_write = 1;
    push(1'b0, op, z, 1'b1, e);
    e = '0; e.illegal = (op >= 4'd9 && op <= 4'd14);
    push(1'b0, op, z, 1'b1, e);
    case (op)
      4'd1, 4'd2, 4'd7, 4'd8: begin
        e = '0; e.alu_ctl = op;   push(1'b0, op, z, 1'b1, e);
        e = '0; e.reg_write = 1;  push(1'b0, op, z, 1'b1, e);
      end
      4'd4, 4'd5: begin
        e = '0; e.alu_ctl = op;   push(1'b0, op, z, 1'b1, e);
        for (int i = 0; i <= mw; i++) begin
          e = '0; e.mem_req = 1; e.iord = 1;
          e.mem_read = (op == 4'd4); e.mem_write = (op == 4'd5);
          push(1'b0, op, z, (i == mw), e);
        end
        if (op == 4'd4) begin
          e = '0; e.reg_write = 1; e.mem_to_reg = 1;
          push(1'b0, op, z, 1'b1, e);
        end
      end
      4'd3, 4'd6: begin
        e = '0; e.alu_ctl = op; e.pc_src = 1; e.pc_write = z;
        push(1'b0, op, z, 1'b1, e);
      end
      4'd15: begin
        for (int i = 0; i < 20; i++) begin
          e = '0; e.halted = 1;
          push(1'b0, op, z, 1'($urandom_range(0, 1)), e);
        end
      end
      default: ;
    endcase
    if (op != 4'd15) ret_m = ret_m + 16'd1;
  endtask

  task automatic pin(input string nm, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    n_tests++;
    if (idx >= lg.size() || got !== want) begin
      n_fail++;
      $display("FAIL %s @%0d got=%0h want=%0h", nm, idx, got, want);
    end
  endtask

  int i_cnt, i_lw, i_b1, i_b0, i_n1, i_n0, i_ill, i_perf, i_rst, i_h;

  initial begin
    outv_t got, e;
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;

    push_reset(2);
    i_cnt = q.size(); gen(4'd7, 1'b0, 0, 0);
    i_lw  = q.size(); gen(4'd4, 1'b0, 0, 2);
    i_b1  = q.size(); gen(4'd6, 1'b1, 0, 0);
    i_b0  = q.size(); gen(4'd6, 1'b0, 0, 0);
    i_n1  = q.size(); gen(4'd3, 1'b1, 0, 0);
    i_n0  = q.size(); gen(4'd3, 1'b0, 1, 0);
    i_ill = q.size(); gen(4'd11, 1'b0, 0, 0);
    gen(4'd0, 1'b1, 2, 0);
    gen(4'd5, 1'b0, 0, 1);
    gen(4'd1, 1'b0, 0, 0);
    gen(4'd2, 1'b1, 0, 0);
    gen(4'd8, 1'b0, 1, 0);
    gen(4'd9, 1'b0, 0, 0);
    gen(4'd14, 1'b0, 0, 0);
    push_reset(1);
    gen(4'd0, 1'b0, 0, 0);
    gen(4'd5, 1'b0, 0, 0);
    gen(4'd6, 1'b1, 0, 0);
    gen(4'd7, 1'b0, 0, 0);
    i_perf = q.size();
    gen(4'd4, 1'b0, 0, 5);
    for (int k = 0; k < 4; k++) void'(q.pop_back());
    i_rst = q.size(); push_reset(1);
    gen(4'd0, 1'b0, 0, 0);
    i_h = q.size(); gen(4'd15, 1'b0, 0, 0);
    push_reset(2);
    gen(4'd7, 1'b0, 0, 0);
    gen(4'd0, 1'b0, 0, 0);

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clock);
      #1;
      reset = q[i].rst; opcode = q[i].op; zero = q[i].z; mem_ready = q[i].rdy;
      @(negedge clock);
      got = '0;
      got.mem_req = mem_req; got.mem_read = mem_read; got.mem_write = mem_write;
      got.iord = iord; got.ir_write = ir_write; got.pc_write = pc_write;
      got.pc_src = pc_src; got.reg_write = reg_write; got.mem_to_reg = mem_to_reg;
      got.alu_ctl = alu_ctl; got.halted = halted; got.illegal = illegal;
      e = q[i].exp;
`ifdef CTRL_PERF_EN
      got.retired = retired;
`else
      e.retired = 16'd0;
`endif
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle%0d outputs got=%h want=%h", i, got, e);
      end
      lg.push_back(got);
    end

    pin("cnt_ir_write",  i_cnt,     16'(lg[i_cnt].ir_write),      16'd1);
    pin("cnt_alu",       i_cnt + 2, 16'(lg[i_cnt + 2].alu_ctl),   16'd7);
    pin("cnt_reg_write", i_cnt + 3, 16'(lg[i_cnt + 3].reg_write), 16'd1);
    pin("cnt_refetch",   i_cnt + 4, 16'(lg[i_cnt + 4].mem_req),   16'd1);
    for (int k = 3; k <= 5; k++)
      pin("lw_hold", i_lw + k,
          16'({lg[i_lw + k].mem_req, lg[i_lw + k].iord, lg[i_lw + k].mem_read}), 16'd7);
    pin("lw_memwb", i_lw + 6,
        16'({lg[i_lw + 6].reg_write, lg[i_lw + 6].mem_to_reg}), 16'd3);
    pin("beq_taken",  i_b1 + 2, 16'({lg[i_b1 + 2].pc_write, lg[i_b1 + 2].pc_src}), 16'd3);
    pin("beq_nt",     i_b0 + 2, 16'({lg[i_b0 + 2].pc_write, lg[i_b0 + 2].pc_src}), 16'd1);
    pin("bne_taken",  i_n1 + 2, 16'({lg[i_n1 + 2].pc_write, lg[i_n1 + 2].pc_src}), 16'd3);
    pin("bne_nt",     i_n0 + 3, 16'({lg[i_n0 + 3].pc_write, lg[i_n0 + 3].pc_src}), 16'd1);
    pin("ill_flag",   i_ill + 1, 16'(lg[i_ill + 1].illegal), 16'd1);
    pin("ill_refetch", i_ill + 2,
        16'({lg[i_ill + 2].illegal, lg[i_ill + 2].mem_req, lg[i_ill + 2].reg_write}), 16'd2);
    pin("rst_pre",    i_rst - 1, 16'(lg[i_rst - 1].mem_req), 16'd1);
    pin("rst_cyc",    i_rst,     16'(lg[i_rst].mem_req),     16'd0);
    pin("rst_blank",  i_rst + 1, 16'(lg[i_rst + 1].mem_req), 16'd0);
    pin("rst_resume", i_rst + 2, 16'(lg[i_rst + 2].mem_req), 16'd1);
    pin("halt_last",  i_h + 21,  16'(lg[i_h + 21].halted),   16'd1);
`ifdef CTRL_PERF_EN
    pin("perf_retired", i_perf, lg[i_perf].retired, 16'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
